// File: rtl/port_input_conditioner.sv
// Input pin conditioner: per-bit 2-flop synchronizer followed by a counter debouncer,
// producing a stable level bus, registered edge pulses and sticky rise-event flags.
module port_input_conditioner #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw_in,
   input  logic [WIDTH-1:0] clr_events,
   output logic [WIDTH-1:0] port_value,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic [WIDTH-1:0] event_sticky
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] value_q, value_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   // Two-stage synchronizer; nothing may sit between the stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
      end
   end

   // Per-bit debounce: a counter of consecutive cycles the synced bit disagrees with the stable level.
   always_comb begin
      value_d = value_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (sync2_q[i] == value_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            value_d[i] = sync2_q[i];
            cnt_d[i]   = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Edge pulses track the level update; a rise wins over a same-cycle clear.
   always_comb begin
      rise_d   = value_d & ~value_q;
      fall_d   = ~value_d & value_q;
      sticky_d = rise_d | (sticky_q & ~clr_events);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q  <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         sticky_q <= '0;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         value_q  <= value_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         sticky_q <= sticky_d;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign port_value   = value_q;
   assign rise_pulse   = rise_q;
   assign fall_pulse   = fall_q;
   assign event_sticky = sticky_q;

endmodule

// File: tb/tb_port_input_conditioner.sv
// Directed bench for port_input_conditioner; three instances cover debounce depths 16, 4 and 8.
module tb_port_input_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] raw_in;
   logic [3:0] clr_events;

   logic [3:0] pv16, rp16, fp16, es16;
   logic [3:0] pv4,  rp4,  fp4,  es4;
   logic [3:0] pv8,  rp8,  fp8,  es8;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   port_input_conditioner #(.WIDTH(4), .DEBOUNCE_CYCLES(16)) u16 (
      .clk(clk), .rst(rst), .raw_in(raw_in), .clr_events(clr_events),
      .port_value(pv16), .rise_pulse(rp16), .fall_pulse(fp16), .event_sticky(es16));

   port_input_conditioner #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) u4 (
      .clk(clk), .rst(rst), .raw_in(raw_in), .clr_events(clr_events),
      .port_value(pv4), .rise_pulse(rp4), .fall_pulse(fp4), .event_sticky(es4));

   port_input_conditioner #(.WIDTH(4), .DEBOUNCE_CYCLES(8)) u8 (
      .clk(clk), .rst(rst), .raw_in(raw_in), .clr_events(clr_events),
      .port_value(pv8), .rise_pulse(rp8), .fall_pulse(fp8), .event_sticky(es8));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      raw_in     = 4'h0;
      clr_events = 4'h0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] seen_rise;
      logic [3:0] seen_pv;
      int         rise_at;

      // 1: reset with pins high, D=16
      rst        = 1'b1;
      raw_in     = 4'hF;
      clr_events = 4'h0;
      tick();
      chk("rst_pv", 32'(pv16), 32'h0);
      chk("rst_rp_fp", 32'({rp16, fp16}), 32'h0);
      tick();
      chk("rst_es", 32'(es16), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 17; i++) tick();
      chk("t1_pv_e17", 32'(pv16), 32'h0);
      tick();
      chk("t1_pv_e18", 32'(pv16), 32'hF);
      chk("t1_rp_e18", 32'(rp16), 32'hF);
      chk("t1_es_e18", 32'(es16), 32'hF);
      tick();
      chk("t1_rp_e19", 32'(rp16), 32'h0);
      chk("t1_pv_e19", 32'(pv16), 32'hF);

      // 2: clean step on bit0, D=4
      do_reset();
      raw_in = 4'h1;
      for (int i = 0; i < 5; i++) tick();
      chk("t2_pv_k4", 32'(pv4), 32'h0);
      tick();
      chk("t2_pv_k5", 32'(pv4), 32'h1);
      chk("t2_rp_k5", 32'(rp4), 32'h1);
      chk("t2_fp_k5", 32'(fp4), 32'h0);
      tick();
      chk("t2_rp_k6", 32'(rp4), 32'h0);

      // 3: glitch of 3 cycles rejected, 4 cycles accepted, D=4
      do_reset();
      seen_rise = 4'h0;
      raw_in = 4'h2;
      for (int i = 0; i < 3; i++) begin tick(); seen_rise |= rp4; end
      raw_in = 4'h0;
      for (int i = 0; i < 10; i++) begin tick(); seen_rise |= rp4 | pv4; end
      chk("t3_glitch_pv_rp", 32'(seen_rise), 32'h0);
      chk("t3_glitch_es", 32'(es4), 32'h0);
      raw_in = 4'h2;
      for (int i = 0; i < 4; i++) begin tick(); seen_rise |= rp4; end
      raw_in = 4'h0;
      for (int i = 0; i < 4; i++) begin tick(); seen_rise |= rp4; end
      chk("t3_accept_rise", 32'(seen_rise), 32'h2);
      chk("t3_accept_es", 32'(es4), 32'h2);

      // 4: sticky clear, and rise beating a same-edge clear, D=4
      do_reset();
      raw_in = 4'h4;
      for (int i = 0; i < 7; i++) tick();
      chk("t4_es_set", 32'(es4), 32'h4);
      clr_events = 4'h4;
      tick();
      clr_events = 4'h0;
      chk("t4_es_clr", 32'(es4), 32'h0);
      raw_in = 4'h0;
      for (int i = 0; i < 8; i++) tick();
      chk("t4_pv_fell", 32'(pv4), 32'h0);
      raw_in = 4'h4;
      for (int i = 0; i < 5; i++) tick();
      chk("t4_pv_pre", 32'(pv4), 32'h0);
      clr_events = 4'h4;
      tick();
      chk("t4_rp_clr_edge", 32'(rp4), 32'h4);
      chk("t4_es_rise_wins", 32'(es4), 32'h4);
      clr_events = 4'h0;
      tick();
      chk("t4_es_hold", 32'(es4), 32'h4);

      // 5: reset mid-pending discards count, D=8
      do_reset();
      raw_in = 4'h8;
      for (int i = 0; i < 7; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      chk("t5_pv_e9", 32'(pv8), 32'h0);
      tick();
      chk("t5_pv_e10", 32'(pv8), 32'h8);
      chk("t5_rp_e10", 32'(rp8), 32'h8);

      // 6: bit0 chatters every 2 cycles, bit1 steps, D=4
      do_reset();
      seen_pv = 4'h0;
      seen_rise = 4'h0;
      rise_at = -1;
      for (int i = 0; i < 16; i++) begin
         raw_in = {2'b00, 1'b1, 1'((i >> 1) & 1)};
         tick();
         seen_pv   |= pv4;
         seen_rise |= rp4;
         if (pv4[1] && rise_at < 0) rise_at = i;
      end
      chk("t6_bit0_pv", 32'(seen_pv[0]), 32'h0);
      chk("t6_bit0_rp", 32'(seen_rise[0]), 32'h0);
      chk("t6_bit1_latency", 32'(rise_at), 32'd5);
      raw_in = 4'h0;
      for (int i = 0; i < 5; i++) tick();
      chk("t6_pv_pre_fall", 32'(pv4), 32'h2);
      tick();
      chk("t6_pv_fall", 32'(pv4), 32'h0);
      chk("t6_fp_fall", 32'(fp4), 32'h2);
      tick();
      chk("t6_fp_clear", 32'(fp4), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
